// File: rtl/uart_loop_top.sv
// -----------------------------------------------------------------------------
// uart_loop_top
//
// Self-contained 8N1 UART transceiver used as a link self-test block. The
// transmitter repeats the byte on tx_dfifo back to back, with one extra idle
// bit between frames. The receiver deserialises rxd and holds the last
// correctly framed byte. Tie txd to rxd externally for a loopback test.
//
// Ports:
//   clk       in   1  system clock, all logic on the rising edge
//   rstn      in   1  synchronous reset, active HIGH (despite the name)
//   tx_dfifo  in   8  byte to transmit, latched at each frame start
//   rxd       in   1  asynchronous serial receive line, idle high
//   txd       out  1  serial transmit line, idle high
//   rx_dfifo  out  8  last byte received with a valid stop bit
//
// Parameters:
//   CLK_FREQ      system clock frequency in Hz
//   BAUD          line rate in bit/s
//   CLKS_PER_BIT  clocks per bit period (must be >= 4)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// uart_tx
//
// Free-running 8N1 transmitter. Each frame is one idle bit, one start bit,
// eight data bits (LSB first) and one stop bit: 11 bit periods in total.
//
// Ports:
//   clk   in   1  system clock
//   rstn  in   1  synchronous reset, active high
//   data  in   8  byte to send, captured at the end of the idle bit
//   txd   out  1  registered serial output
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKS_PER_BIT = 86
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] data,
    output logic       txd
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    tx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shreg;

    // One bit-period counter paces every state. All state changes, and every
    // change on txd, happen on the last clock of a bit period, so each bit
    // (idle, start, data, stop) lasts exactly CLKS_PER_BIT clocks. The byte is
    // captured into the shift register at the idle->start boundary, which is
    // why a change on data mid-frame only shows up in the next frame.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state <= TX_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            txd   <= 1'b1;
        end else begin
            if (cnt != BIT_LAST) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
                case (state)
                    TX_IDLE: begin
                        shreg <= data;
                        txd   <= 1'b0;
                        state <= TX_START;
                    end
                    TX_START: begin
                        txd   <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                        idx   <= '0;
                        state <= TX_DATA;
                    end
                    TX_DATA: begin
                        if (idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= TX_STOP;
                        end else begin
                            txd   <= shreg[0];
                            shreg <= {1'b0, shreg[7:1]};
                            idx   <= idx + 1'b1;
                        end
                    end
                    TX_STOP: begin
                        // txd is already high; the following idle bit forms
                        // the inter-frame gap.
                        state <= TX_IDLE;
                    end
                    default: begin
                        txd   <= 1'b1;
                        state <= TX_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// -----------------------------------------------------------------------------
// uart_rx
//
// 8N1 receiver with a two-flop input synchroniser, start-bit glitch
// rejection, centre sampling and stop-bit validation.
//
// Ports:
//   clk   in   1  system clock
//   rstn  in   1  synchronous reset, active high
//   rxd   in   1  asynchronous serial input, idle high
//   data  out  8  last byte received with a valid stop bit
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 86
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    output logic [7:0] data
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shreg;
    logic             rx_meta;
    logic             rx_sync;
    logic             wait_high;

    // The synchroniser flops reset to the idle level so that leaving reset
    // never looks like a falling start edge.
    //
    // The start bit is confirmed half a bit after the falling edge; from then
    // on every sample is taken one full bit period later, which lands each
    // sample at the centre of its bit. A low stop sample is a framing error:
    // the byte is discarded and the receiver parks in STOP (wait_high) until
    // the line is idle again, so a stuck-low line cannot retrigger a frame.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state     <= RX_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            data      <= 8'h00;
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            wait_high <= 1'b0;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
            case (state)
                RX_IDLE: begin
                    cnt       <= '0;
                    wait_high <= 1'b0;
                    if (!rx_sync) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            state <= RX_IDLE;
                        end else begin
                            idx   <= '0;
                            state <= RX_DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_sync, shreg[7:1]};
                        if (idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (wait_high) begin
                        if (rx_sync) begin
                            wait_high <= 1'b0;
                            state     <= RX_IDLE;
                        end
                    end else if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            data  <= shreg;
                            state <= RX_IDLE;
                        end else begin
                            wait_high <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// -----------------------------------------------------------------------------
// uart_loop_top: transmitter and receiver side by side, fully independent.
// -----------------------------------------------------------------------------
module uart_loop_top #(
    parameter int CLK_FREQ     = 10_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] tx_dfifo,
    input  logic       rxd,
    output logic       txd,
    output logic [7:0] rx_dfifo
);

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk (clk),
        .rstn(rstn),
        .data(tx_dfifo),
        .txd (txd)
    );

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk (clk),
        .rstn(rstn),
        .rxd (rxd),
        .data(rx_dfifo)
    );

endmodule

// File: tb/tb_uart_loop_top.sv
// -----------------------------------------------------------------------------
// tb_uart_loop_top
//
// Directed bench for uart_loop_top with CLKS_PER_BIT = 86. rxd is either
// looped back from txd or driven directly by the bench. cyc counts clock
// edges since the last reset edge, so "cyc == k" means k edges after reset.
// -----------------------------------------------------------------------------
module tb_uart_loop_top;

    localparam int CPB   = 86;
    localparam int FRAME = 11 * CPB;

    logic       clk;
    logic       rstn;
    logic [7:0] tx_dfifo;
    logic       rxd;
    logic       txd;
    logic [7:0] rx_dfifo;
    logic       loop_en;
    logic       rxd_drv;

    int checks;
    int errors;
    int cyc;

    assign rxd = loop_en ? txd : rxd_drv;

    uart_loop_top #(
        .CLK_FREQ(10_000_000),
        .BAUD    (115200)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .tx_dfifo(tx_dfifo),
        .rxd     (rxd),
        .txd     (txd),
        .rx_dfifo(rx_dfifo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used as the time reference for all directed checks.
    always @(posedge clk) begin
        if (rstn) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Compare one observed value with its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one 8N1 frame onto rxd, then two idle bits.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd_drv = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rxd_drv = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;
    endtask

    task automatic waitCyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [10:0] a5_frame;
        int bad;
        bit found;

        checks   = 0;
        errors   = 0;
        rstn     = 1'b1;
        loop_en  = 1'b1;
        rxd_drv  = 1'b1;
        tx_dfifo = 8'hA5;

        // Reset state and TX waveform for 8'hA5 (loopback on).
        doReset();
        checkOutput("reset_txd", txd, 1);
        checkOutput("reset_rx", rx_dfifo, 8'h00);
        // idle, start, 1,0,1,0,0,1,0,1, stop
        a5_frame = 11'b1_10100101_0_1;
        waitCyc(43);
        checkOutput("tx_idle_centre", txd, 1);
        waitCyc(85);
        checkOutput("tx_idle_last", txd, 1);
        waitCyc(86);
        checkOutput("tx_start_first", txd, 0);
        for (int b = 1; b < 11; b++) begin
            waitCyc(43 + CPB * b);
            checkOutput($sformatf("tx_bit%0d", b), txd, 32'(a5_frame[b]));
        end
        waitCyc(906);
        checkOutput("loop_a5", rx_dfifo, 8'hA5);

        // Loopback of 8'h5A: exact arrival, then stable for 10 frames.
        tx_dfifo = 8'h5A;
        doReset();
        waitCyc(905);
        checkOutput("loop_before", rx_dfifo, 8'h00);
        waitCyc(906);
        checkOutput("loop_arrive", rx_dfifo, 8'h5A);
        bad = 0;
        for (int i = 0; i < 10 * FRAME; i++) begin
            @(posedge clk);
            #1;
            if (rx_dfifo !== 8'h5A) bad++;
        end
        checkOutput("loop_stable_cycles_bad", bad, 0);

        // Byte change mid-frame: current frame 5A, next frame C3.
        doReset();
        waitCyc(300);
        tx_dfifo = 8'hC3;
        waitCyc(906);
        checkOutput("chg_first_frame", rx_dfifo, 8'h5A);
        waitCyc(FRAME + 905);
        checkOutput("chg_before_stop", rx_dfifo, 8'h5A);
        waitCyc(FRAME + 906);
        checkOutput("chg_second_frame", rx_dfifo, 8'hC3);

        // Direct drive: glitch, good frame, framing error, good frame.
        loop_en = 1'b0;
        rxd_drv = 1'b1;
        waitCyc(2000);
        rxd_drv = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rxd_drv = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        checkOutput("glitch_rx", rx_dfifo, 8'hC3);
        applyStimulus(8'h81, 1'b1);
        checkOutput("after_glitch_rx", rx_dfifo, 8'h81);
        applyStimulus(8'h33, 1'b0);
        checkOutput("frame_err_rx", rx_dfifo, 8'h81);
        applyStimulus(8'h96, 1'b1);
        checkOutput("good_after_err_rx", rx_dfifo, 8'h96);

        // Reset during TX DATA (bit 2 of C3 = 0).
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if ((cyc % FRAME) == 400) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("midframe_found", 32'(found), 1);
        checkOutput("midframe_txd_pre", txd, 0);
        checkOutput("midframe_rx_pre", rx_dfifo, 8'h96);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midframe_txd_post", txd, 1);
        checkOutput("midframe_rx_post", rx_dfifo, 8'h00);
        rstn = 1'b0;
        waitCyc(85);
        checkOutput("fresh_idle_last", txd, 1);
        waitCyc(86);
        checkOutput("fresh_start", txd, 0);
        waitCyc(43 + 2 * CPB);
        checkOutput("fresh_bit0", txd, 1);
        waitCyc(43 + 3 * CPB);
        checkOutput("fresh_bit1", txd, 1);
        waitCyc(43 + 4 * CPB);
        checkOutput("fresh_bit2", txd, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_loop_top.md
Name: uart_loop_top

Overview:
- Self-contained UART transceiver top: 8N1, LSB first, fixed baud derived from the system clock.
- Transmitter sends the byte on tx_dfifo continuously, back to back.
- Receiver deserialises rxd and holds the last correctly framed byte on rx_dfifo.
- Used standalone or in loopback (txd tied to rxd) as a link self-test block.

Parameters:
- CLK_FREQ, 10_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (=86, integer truncation), clocks per bit period; must be >= 4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rstn  input  1  synchronous reset, active-high despite the name; sampled on clk rising edge.
- tx_dfifo  input  8  byte to transmit; sampled at each frame start.
- rxd  input  1  serial receive line, asynchronous; idle high.
- txd  output  1  serial transmit line; idle high.
- rx_dfifo  output  8  last validly received byte.

Behaviour:
- Reset (rstn=1 at a clk edge): txd=1, rx_dfifo=8'h00, both FSMs to IDLE, all counters 0. Reset mid-frame aborts the frame immediately; txd is 1 the cycle after.
- Baud tick: each FSM has its own counter, 0..CLKS_PER_BIT-1. Every bit, including start and stop, lasts exactly CLKS_PER_BIT clocks.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: txd=1 for one bit period after reset or after a stop bit; this is the inter-frame gap of one extra idle bit. Then tx_dfifo is latched into the shift register.
  - START: txd=0 for one bit.
  - DATA: 8 bits, bit0 first; a 3-bit index counts 0..7.
  - STOP: txd=1 for one bit.
  - Frame period is therefore 11*CLKS_PER_BIT clocks.
  - A tx_dfifo change mid-frame does not affect the current frame.
- RX input: rxd passes through a 2-flop synchroniser before any use (2-cycle latency).
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: waits for synchronised rxd=0.
  - START: checks the line at CLKS_PER_BIT/2. If rxd is back to 1, this is a glitch; return to IDLE with no update.
  - DATA: samples each bit at its centre (every CLKS_PER_BIT from the start-centre) and shifts in LSB first.
  - STOP: samples at the stop-bit centre.
    - If 1: rx_dfifo <= shift register on that cycle, then IDLE.
    - If 0 (framing error): rx_dfifo is unchanged. Wait in STOP until the line returns high, then IDLE.
- rx_dfifo changes only on a valid stop sample. It is stable otherwise, including across repeated identical frames.
- TX and RX are independent; simultaneous activity is allowed.
- Loopback latency: reset release to rx_dfifo valid = 1 idle bit + 9.5 bits + 2 sync clocks, i.e. about 10.5*CLKS_PER_BIT+3 clocks.

Test Plan:
- Loopback: txd->rxd, tx_dfifo=8'h5A, CLKS_PER_BIT=86. After reset, rx_dfifo=8'h5A within 1000 clocks. It stays 8'h5A through 10 further frames.
- TX waveform, tx_dfifo=8'hA5:
  - txd is high for 86 clocks after reset, then low for 86 clocks (start).
  - Then the bits 1,0,1,0,0,1,0,1 follow, each 86 clocks.
  - Then high for 86 clocks (stop).
- Byte change: tx_dfifo changes 8'h5A -> 8'hC3 mid-frame. The current frame still carries 8'h5A; the next frame carries 8'hC3. In loopback, rx_dfifo updates to 8'hC3 only after that next stop bit.
- Glitch reject: drive rxd low for 20 clocks in idle. rx_dfifo is unchanged and the RX FSM returns to IDLE.
- Framing error: drive a frame of 8'h33 with the stop bit at 0. rx_dfifo keeps its old value. A following good 8'h96 frame yields rx_dfifo=8'h96.
- Reset mid-frame: assert rstn during TX DATA. Next cycle txd=1 and rx_dfifo=8'h00. After release, a full fresh frame starts after one idle bit.
